// File: rtl/decode_pipe.sv
// decode_pipe: instruction queue followed by a registered decoder stage.
// Instructions enter a DEPTH-entry FIFO, are decoded from the FIFO head and
// land in an output register. A one-cycle load-use interlock holds back the
// instruction after a register-writing lw when that instruction reads the
// loaded register.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. in_ready depends only on the queue fill
// level (never on out_ready). While out_valid && !out_ready, every out_*
// signal holds its value.
module decode_pipe #(
  parameter int DEPTH     = 4,
  parameter int HAZARD_EN = 1,
  parameter int CNTW      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [31:0]     in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [31:0]     out_pc,
  output logic [1:0]      out_reg_src,
  output logic            out_reg_dst,
  output logic            out_reg_wr,
  output logic            out_alu_src,
  output logic            out_ram_wr,
  output logic            out_jmp,
  output logic [5:0]      out_alu_op,
  output logic            out_illegal,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          ld_pend;
  logic [4:0]    ld_rt;

  logic [31:0]   head_inst;
  logic [31:0]   head_pc;
  logic [5:0]    head_op;
  logic [4:0]    head_rs;
  logic [4:0]    head_rt;

  logic [1:0]    dec_reg_src;
  logic          dec_reg_dst;
  logic          dec_reg_wr;
  logic          dec_alu_src;
  logic          dec_ram_wr;
  logic          dec_jmp;
  logic [5:0]    dec_alu_op;
  logic          dec_illegal;
  logic          uses_rs;
  logic          uses_rt;

  logic          push;
  logic          want_load;
  logic          hazard;
  logic          blocked;
  logic          load;
  logic          set_ld_pend;

  assign head_inst = mem_inst[rd_ptr];
  assign head_pc   = mem_pc[rd_ptr];
  assign head_op   = head_inst[31:26];
  assign head_rs   = head_inst[25:21];
  assign head_rt   = head_inst[20:16];

  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid && in_ready;

  // The output register can take a new word when it is empty or being drained.
  assign want_load = (count != '0) && (!out_valid || out_ready);
  assign hazard    = (HAZARD_EN != 0) && ld_pend &&
                     ((uses_rs && (head_rs == ld_rt)) ||
                      (uses_rt && (head_rt == ld_rt)));
  assign blocked   = want_load && hazard;
  assign load      = want_load && !hazard;

  // A register-writing lw entering the output register arms the interlock
  // for exactly the following cycle.
  assign set_ld_pend = (HAZARD_EN != 0) && load &&
                       (head_op == OP_LW) && (head_rt != 5'd0);

  // Decode the FIFO head and note which source registers it reads.
  always_comb begin
    dec_reg_src = 2'd0;
    dec_reg_dst = 1'b0;
    dec_reg_wr  = 1'b0;
    dec_alu_src = 1'b0;
    dec_ram_wr  = 1'b0;
    dec_jmp     = 1'b0;
    dec_alu_op  = 6'd0;
    dec_illegal = 1'b0;
    uses_rs     = 1'b0;
    uses_rt     = 1'b0;
    case (head_op)
      OP_R: begin
        dec_reg_dst = 1'b1;
        dec_reg_wr  = 1'b1;
        dec_alu_op  = head_inst[5:0];
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_alu_op  = 6'h22;
        dec_jmp     = 1'b1;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_ADDI: begin
        dec_reg_wr  = 1'b1;
        dec_alu_op  = 6'h20;
        dec_alu_src = 1'b1;
        uses_rs     = 1'b1;
      end
      OP_LW: begin
        dec_reg_src = 2'd1;
        dec_reg_wr  = 1'b1;
        dec_alu_op  = 6'h20;
        dec_alu_src = 1'b1;
        uses_rs     = 1'b1;
      end
      OP_SW: begin
        dec_alu_op  = 6'h20;
        dec_alu_src = 1'b1;
        dec_ram_wr  = 1'b1;
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
      end
      OP_J: begin
        dec_jmp     = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Queue storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  // Queue pointers and fill level; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(load);
    end
  end

  // Output register: loads a decoded head, empties when accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_inst    <= 32'd0;
      out_pc      <= 32'd0;
      out_reg_src <= 2'd0;
      out_reg_dst <= 1'b0;
      out_reg_wr  <= 1'b0;
      out_alu_src <= 1'b0;
      out_ram_wr  <= 1'b0;
      out_jmp     <= 1'b0;
      out_alu_op  <= 6'd0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_inst    <= head_inst;
      out_pc      <= head_pc;
      out_reg_src <= dec_reg_src;
      out_reg_dst <= dec_reg_dst;
      out_reg_wr  <= dec_reg_wr;
      out_alu_src <= dec_alu_src;
      out_ram_wr  <= dec_ram_wr;
      out_jmp     <= dec_jmp;
      out_alu_op  <= dec_alu_op;
      out_illegal <= dec_illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Load-use interlock state: pending flag lives for one cycle only.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ld_pend <= 1'b0;
      ld_rt   <= 5'd0;
    end else begin
      ld_pend <= set_ld_pend;
      if (set_ld_pend) ld_rt <= head_rt;
    end
  end

  // Bubble counter: one per cycle a ready load is held back, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!flush && blocked && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: directed scenarios plus a randomized stream, with a
// queue-based scoreboard and a table-driven reference decoder.
module tb_decode_pipe;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [31:0]     in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic [31:0]     out_pc;
  logic [1:0]      out_reg_src;
  logic            out_reg_dst;
  logic            out_reg_wr;
  logic            out_alu_src;
  logic            out_ram_wr;
  logic            out_jmp;
  logic [5:0]      out_alu_op;
  logic            out_illegal;
  logic [CNTW-1:0] stall_cnt;

  decode_pipe #(.DEPTH(DEPTH), .HAZARD_EN(1), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_reg_src(out_reg_src), .out_reg_dst(out_reg_dst), .out_reg_wr(out_reg_wr),
    .out_alu_src(out_alu_src), .out_ram_wr(out_ram_wr), .out_jmp(out_jmp),
    .out_alu_op(out_alu_op), .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] pc_next;
  int          exp_stall;

  // {reg_src, reg_dst, reg_wr, alu_src, ram_wr, jmp, alu_op, illegal}
  logic [13:0] obs_dec;
  assign obs_dec = {out_reg_src, out_reg_dst, out_reg_wr, out_alu_src,
                    out_ram_wr, out_jmp, out_alu_op, out_illegal};

  function automatic logic [13:0] ref_dec(input logic [31:0] w);
    case (w[31:26])
      6'd0:       return {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, w[5:0], 1'b0};
      6'd4, 6'd5: return {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h22,  1'b0};
      6'd8:       return {2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h20,  1'b0};
      6'd35:      return {2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'h20,  1'b0};
      6'd43:      return {2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'h20,  1'b0};
      6'd2:       return {2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00,  1'b0};
      default:    return 14'd1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every accepted output word must be the oldest outstanding push.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin : mon
      logic [31:0] ei;
      logic [31:0] ep;
      ei = 32'hx;
      ep = 32'hx;
      if (exp_q.size() != 0) begin
        ei = exp_q.pop_front();
        ep = pc_q.pop_front();
      end
      check("sb_inst", out_inst, ei);
      check("sb_pc", out_pc, ep);
      check("sb_decode", obs_dec, ref_dec(ei));
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 8))
      0: w[31:26] = 6'd0;
      1: w[31:26] = 6'd4;
      2: w[31:26] = 6'd5;
      3: w[31:26] = 6'd8;
      4: w[31:26] = 6'd35;
      5: w[31:26] = 6'd43;
      6: w[31:26] = 6'd2;
      7: w[31:26] = 6'h3F;
      default: ;
    endcase
    // Keep register numbers small so load-use collisions actually happen.
    w[25:21] = 5'($urandom_range(0, 3));
    w[20:16] = 5'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic logic [31:0] addi_word(input int k);
    logic [4:0]  rt;
    logic [15:0] imm;
    rt  = 5'(k + 1);
    imm = 16'($urandom());
    return {6'd8, 5'd0, rt, imm};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [31:0] inst);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc_next;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("push_accepted", ok, 1'b1);
    if (ok) begin
      exp_q.push_back(inst);
      pc_q.push_back(pc_next);
      pc_next = pc_next + 32'd4;
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic flush_test(input int npre);
    int seen;
    out_ready = 1'b0;
    for (int k = 0; k < npre; k++) push(addi_word(k));
    in_inst  = 32'h2000_BEEF;
    in_pc    = pc_next;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    pc_q.delete();
    @(negedge clk);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_stall_kept", stall_cnt, exp_stall);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_nothing_left", seen, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : main
    logic [31:0] w [DEPTH+2];
    logic        fire;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b0;
    pc_next   = 32'h0000_1000;
    exp_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_stall", stall_cnt, 0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_dec", obs_dec, 14'd0);
    @(posedge clk);
    #1;

    // addi latency and decode
    out_ready = 1'b1;
    push(32'h2001_0005);
    @(negedge clk);
    check("addi_valid_edge1", out_valid, 1'b0);
    @(negedge clk);
    check("addi_valid_edge2", out_valid, 1'b1);
    check("addi_reg_wr", out_reg_wr, 1'b1);
    check("addi_alu_src", out_alu_src, 1'b1);
    check("addi_alu_op", out_alu_op, 6'h20);
    check("addi_reg_dst", out_reg_dst, 1'b0);
    @(posedge clk);
    #1;
    drain();

    // lw $1 then add $2,$1,$3: one bubble
    push(32'h8C01_0004);
    push(32'h0023_1020);
    exp_stall = exp_stall + 1;
    @(negedge clk);
    check("haz_lw_out", out_inst, 32'h8C01_0004);
    @(negedge clk);
    check("haz_bubble", out_valid, 1'b0);
    check("haz_stall_cnt", stall_cnt, exp_stall);
    @(negedge clk);
    check("haz_add_valid", out_valid, 1'b1);
    check("haz_add_inst", out_inst, 32'h0023_1020);
    @(posedge clk);
    #1;
    drain();

    // lw $0 then add $2,$0,$3: no bubble
    push(32'h8C00_0004);
    push(32'h0003_1020);
    @(negedge clk);
    check("nohaz_lw_out", out_inst, 32'h8C00_0004);
    @(negedge clk);
    check("nohaz_add_valid", out_valid, 1'b1);
    check("nohaz_add_inst", out_inst, 32'h0003_1020);
    check("nohaz_stall_cnt", stall_cnt, exp_stall);
    @(posedge clk);
    #1;
    drain();

    // Backpressure: DEPTH+2 words with out_ready low
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) w[k] = addi_word(k);
    for (int k = 0; k < DEPTH + 1; k++) push(w[k]);
    in_inst  = w[DEPTH+1];
    in_pc    = pc_next;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 1'b0);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_inst", out_inst, w[0]);
      check("bp_hold_dec", obs_dec, ref_dec(w[0]));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(w[DEPTH+1]);
    drain();

    // Illegal opcode flows through, pipeline keeps going
    push(32'hFC00_1234 | ($urandom() & 32'h03FF_0000));
    push(32'h2002_0007);
    drain();

    // Flush with a full queue, then with a real same-cycle push
    flush_test(DEPTH + 1);
    flush_test(1);

    // Reset mid-stream
    out_ready = 1'b0;
    push(addi_word(3));
    push(addi_word(4));
    reset    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'h2003_0009;
    in_pc    = pc_next;
    @(negedge clk);
    @(negedge clk);
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_out_inst", out_inst, 32'd0);
    check("rst2_out_pc", out_pc, 32'd0);
    check("rst2_out_dec", obs_dec, 14'd0);
    check("rst2_stall", stall_cnt, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    pc_q.delete();
    exp_stall = 0;
    @(negedge clk);
    check("rst2_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(32'h2004_0011);
    push(32'hAC05_0008);
    drain();

    // Randomized stream with random backpressure
    for (int c = 0; c < 400; c++) begin
      if (!in_valid) begin
        in_inst  = rand_inst();
        in_pc    = pc_next;
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        exp_q.push_back(in_inst);
        pc_q.push_back(in_pc);
        pc_next  = pc_next + 32'd4;
        in_valid = 1'b0;
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
